uart_cmd_rx: RTL and testbench

- UART 8N1 receiver plus command assembler; the input-side counterpart of the existing UART transmit path.
- Deserialises bytes on `rx`, assembles two-byte command frames into `a`, `b` and `opcode`, and presents them to the FSM core over a valid/ready handshake.
- Flags framing, header, timeout and overrun errors as one-cycle pulses.

---
 rtl/jsilicon_pkg.sv | 42 ++++
 rtl/uart_cmd_rx_if.sv | 33 +++
 rtl/uart_rx_core.sv | 130 +++++++++++++
 rtl/uart_cmd_rx.sv | 112 +++++++++++
 tb/tb_uart_cmd_rx.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/jsilicon_pkg.sv
// rtl/jsilicon_pkg.sv - shared constants, state enums and command type for the UART command receiver
//
// Contents:
//   CLKS_PER_BIT_DEF, TIMEOUT_BITS_DEF, HDR_DEF  default UART / frame constants
//   byte_state_t   byte receiver FSM states
//   frame_state_t  two-byte frame assembler FSM states
//   cmd_t          decoded command {a, b, opcode}
//   make_cmd       packs byte0 and the byte1 opcode field into a cmd_t
package jsilicon_pkg;

  localparam int         CLKS_PER_BIT_DEF = 434;
  localparam int         TIMEOUT_BITS_DEF = 20;
  localparam logic [4:0] HDR_DEF          = 5'b10100;

  typedef enum logic [2:0] {
    BS_IDLE,
    BS_START,
    BS_DATA,
    BS_STOP,
    BS_BREAK
  } byte_state_t;

  typedef enum logic {
    FS_WAIT0,
    FS_WAIT1
  } frame_state_t;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] opcode;
  } cmd_t;

  function automatic cmd_t make_cmd(input logic [7:0] byte0, input logic [2:0] op);
    cmd_t c;
    c.a      = byte0[7:4];
    c.b      = byte0[3:0];
    c.opcode = op;
    return c;
  endfunction

endpackage

// File: rtl/uart_cmd_rx_if.sv
// rtl/uart_cmd_rx_if.sv - command valid/ready channel between receiver and consumer
//
// Signals:
//   cmd_valid   command pending (driven by master)
//   cmd_ready   consumer accepts when high with cmd_valid (driven by slave)
//   cmd_a       operand A
//   cmd_b       operand B
//   cmd_opcode  opcode
interface uart_cmd_rx_if;

  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic [2:0] cmd_opcode;

  modport master (
    output cmd_valid,
    output cmd_a,
    output cmd_b,
    output cmd_opcode,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_a,
    input  cmd_b,
    input  cmd_opcode,
    output cmd_ready
  );

endinterface

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - 8N1 byte receiver: rx synchroniser plus byte FSM
//
// Ports:
//   clock       system clock
//   reset_n     asynchronous active-low reset
//   rx          serial line, idle high, asynchronous to clock
//   byte_valid  one-cycle pulse, byte_data holds a good byte
//   byte_data   last received byte (LSB first on the line)
//   frame_err   one-cycle pulse, stop bit sampled low
//   busy        high whenever the byte FSM is not in IDLE
module uart_rx_core
  import jsilicon_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err,
  output logic       busy
);

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  logic          rx_meta;
  logic          rxs;
  logic          rxs_prev;
  byte_state_t   state;
  logic [CW-1:0] cyc_cnt;
  logic [3:0]    bit_idx;
  logic [7:0]    shift;

  // Flops reset high so an idle line never looks like a falling edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta  <= 1'b1;
      rxs      <= 1'b1;
      rxs_prev <= 1'b1;
    end else begin
      rx_meta  <= rx;
      rxs      <= rx_meta;
      rxs_prev <= rxs;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= BS_IDLE;
      cyc_cnt    <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      unique case (state)
        BS_IDLE: begin
          if (rxs_prev && !rxs) begin
            state   <= BS_START;
            cyc_cnt <= '0;
            busy    <= 1'b1;
          end
        end
        // Sample mid start bit; a high line here was only a glitch.
        BS_START: begin
          if (cyc_cnt == HALF_LAST) begin
            cyc_cnt <= '0;
            if (rxs) begin
              state <= BS_IDLE;
              busy  <= 1'b0;
            end else begin
              state   <= BS_DATA;
              bit_idx <= '0;
            end
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        BS_DATA: begin
          if (cyc_cnt == BIT_LAST) begin
            cyc_cnt <= '0;
            shift   <= {rxs, shift[7:1]};
            if (bit_idx == 4'd7) begin
              state <= BS_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        BS_STOP: begin
          if (cyc_cnt == BIT_LAST) begin
            cyc_cnt <= '0;
            if (rxs) begin
              byte_valid <= 1'b1;
              state      <= BS_IDLE;
              busy       <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= BS_BREAK;
            end
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        // Wait for the line to recover so a held-low line cannot retrigger.
        BS_BREAK: begin
          if (rxs) begin
            state <= BS_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= BS_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign byte_data = shift;

endmodule

// File: rtl/uart_cmd_rx.sv
// rtl/uart_cmd_rx.sv - UART receiver plus two-byte command assembler with valid/ready output
//
// Ports:
//   clock        system clock
//   reset_n      asynchronous active-low reset
//   rx           serial line, idle high
//   cmd          command channel (master): cmd_valid/cmd_ready, cmd_a, cmd_b, cmd_opcode
//   rx_busy      byte receiver not idle
//   frame_err    one-cycle pulse, stop bit low
//   cmd_err      one-cycle pulse, header mismatch or byte1 timeout
//   overrun_err  one-cycle pulse, frame completed while a command was still pending
module uart_cmd_rx
  import jsilicon_pkg::*;
#(
  parameter int         CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int         TIMEOUT_BITS = TIMEOUT_BITS_DEF,
  parameter logic [4:0] HDR          = HDR_DEF
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          rx,
  uart_cmd_rx_if.master cmd,
  output logic          rx_busy,
  output logic          frame_err,
  output logic          cmd_err,
  output logic          overrun_err
);

  localparam int            CW       = $clog2(CLKS_PER_BIT);
  localparam int            TW       = $clog2(TIMEOUT_BITS + 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT_BITS);

  logic         byte_valid;
  logic [7:0]   byte_data;
  frame_state_t fstate;
  logic [7:0]   byte0;
  logic [CW-1:0] to_cyc;
  logic [TW-1:0] to_bits;
  cmd_t         cmd_q;
  logic         valid_q;

  uart_rx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_core (
    .clock     (clock),
    .reset_n   (reset_n),
    .rx        (rx),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .frame_err (frame_err),
    .busy      (rx_busy)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fstate      <= FS_WAIT0;
      byte0       <= '0;
      to_cyc      <= '0;
      to_bits     <= '0;
      cmd_q       <= '0;
      valid_q     <= 1'b0;
      cmd_err     <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      cmd_err     <= 1'b0;
      overrun_err <= 1'b0;
      // Handshake retires the pending command; a completing frame below may reload it.
      if (valid_q && cmd.cmd_ready) begin
        valid_q <= 1'b0;
      end
      unique case (fstate)
        FS_WAIT0: begin
          if (byte_valid) begin
            byte0   <= byte_data;
            fstate  <= FS_WAIT1;
            to_cyc  <= '0;
            to_bits <= '0;
          end
        end
        FS_WAIT1: begin
          if (byte_valid) begin
            fstate <= FS_WAIT0;
            if (byte_data[7:3] != HDR) begin
              cmd_err <= 1'b1;
            end else if (!valid_q || cmd.cmd_ready) begin
              cmd_q   <= make_cmd(byte0, byte_data[2:0]);
              valid_q <= 1'b1;
            end else begin
              overrun_err <= 1'b1;
            end
          end else if (to_bits == TO_LIMIT) begin
            cmd_err <= 1'b1;
            fstate  <= FS_WAIT0;
          end else if (to_cyc == BIT_LAST) begin
            to_cyc  <= '0;
            to_bits <= to_bits + 1'b1;
          end else begin
            to_cyc <= to_cyc + 1'b1;
          end
        end
        default: fstate <= FS_WAIT0;
      endcase
    end
  end

  assign cmd.cmd_valid  = valid_q;
  assign cmd.cmd_a      = cmd_q.a;
  assign cmd.cmd_b      = cmd_q.b;
  assign cmd.cmd_opcode = cmd_q.opcode;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// tb/tb_uart_cmd_rx.sv - self-checking bench for uart_cmd_rx
module tb_uart_cmd_rx;

  localparam int         CPB     = 8;
  localparam int         TO_BITS = 20;
  localparam logic [4:0] HDR     = 5'b10100;

  logic clock = 1'b0;
  logic reset_n;
  logic rx;
  logic rx_busy, frame_err, cmd_err, overrun_err;

  uart_cmd_rx_if cif();

  uart_cmd_rx #(
    .CLKS_PER_BIT(CPB),
    .TIMEOUT_BITS(TO_BITS),
    .HDR         (HDR)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .rx         (rx),
    .cmd        (cif),
    .rx_busy    (rx_busy),
    .frame_err  (frame_err),
    .cmd_err    (cmd_err),
    .overrun_err(overrun_err)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: byte stream -> frames, with expected commands and error counts.
  logic [10:0] exp_q[$];
  bit          have_b0 = 0;
  logic [7:0]  b0_m;
  bit          held = 0;
  int          exp_cmd_err = 0, exp_frame_err = 0, exp_overrun = 0;
  int          seen_cmd_err = 0, seen_frame_err = 0, seen_overrun = 0;
  logic [10:0] mon_exp;
  logic [7:0]  x0, x1;
  int          wait_cnt, busy_cycles;

  task automatic model_byte(input logic [7:0] d);
    if (!have_b0) begin
      have_b0 = 1;
      b0_m    = d;
    end else begin
      have_b0 = 0;
      if (d[7:3] != HDR) exp_cmd_err++;
      else if (cif.cmd_ready) exp_q.push_back({b0_m, d[2:0]});
      else if (held) exp_overrun++;
      else begin
        held = 1;
        exp_q.push_back({b0_m, d[2:0]});
      end
    end
  endtask

  task automatic idle_bits(input int bits);
    if (bits > TO_BITS && have_b0) begin
      exp_cmd_err++;
      have_b0 = 0;
    end
    repeat (bits * CPB) @(negedge clock);
  endtask

  task automatic drive_byte(input logic [7:0] d, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clock);
    end
    rx = stop;
    repeat (CPB) @(negedge clock);
  endtask

  task automatic send(input logic [7:0] d);
    model_byte(d);
    drive_byte(d, 1'b1);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_cmd_err"}, seen_cmd_err, exp_cmd_err);
    check({tag, "_frame_err"}, seen_frame_err, exp_frame_err);
    check({tag, "_overrun"}, seen_overrun, exp_overrun);
    check({tag, "_queue"}, exp_q.size(), 0);
  endtask

  always @(negedge clock) begin
    if (reset_n) begin
      if (cmd_err) seen_cmd_err++;
      if (frame_err) seen_frame_err++;
      if (overrun_err) seen_overrun++;
      if (cif.cmd_valid && cif.cmd_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_cmd", 1, 0);
        end else begin
          mon_exp = exp_q.pop_front();
          check("cmd_fields", {cif.cmd_a, cif.cmd_b, cif.cmd_opcode}, mon_exp);
        end
      end
    end
  end

  initial begin
    reset_n       = 1'b0;
    rx            = 1'b1;
    cif.cmd_ready = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_valid", cif.cmd_valid, 0);
    check("rst_fields", {cif.cmd_a, cif.cmd_b, cif.cmd_opcode}, 0);
    check("rst_busy", rx_busy, 0);
    check("rst_errs", {frame_err, cmd_err, overrun_err}, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // Basic frame
    send(8'h35);
    send(8'hA2);
    idle_bits(2);
    check_counts("basic");

    // Header mismatch, then a good frame
    send(8'h35);
    send(8'h12);
    idle_bits(2);
    check("hdr_valid_low", cif.cmd_valid, 0);
    check("hdr_err", seen_cmd_err, 1);
    send(8'h47);
    send(8'hA5);
    idle_bits(2);
    check_counts("hdr");

    // Stop bit low then held-low line
    exp_frame_err++;
    drive_byte(8'h35, 1'b0);
    repeat (30 * CPB) @(negedge clock);
    check("break_busy", rx_busy, 1);
    check("break_no_cmd", cif.cmd_valid, 0);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clock);
    check("break_idle", rx_busy, 0);
    check_counts("break");

    // Byte1 timeout measured from end of byte0
    send(8'h35);
    exp_cmd_err++;
    have_b0  = 0;
    wait_cnt = 0;
    while (!cmd_err && wait_cnt < 30 * CPB) begin
      @(negedge clock);
      wait_cnt++;
    end
    check("timeout_seen", cmd_err, 1);
    check("timeout_window", (wait_cnt >= 19 * CPB && wait_cnt <= 22 * CPB), 1);
    repeat (5 * CPB) @(negedge clock);
    send(8'hA1);
    send(8'hA1);
    idle_bits(2);
    check_counts("timeout");

    // Overrun with consumer stalled
    @(posedge clock);
    #1 cif.cmd_ready = 1'b0;
    send(8'h12);
    send(8'hA3);
    send(8'h34);
    send(8'hA4);
    idle_bits(2);
    check("ovr_valid", cif.cmd_valid, 1);
    check("ovr_fields", {cif.cmd_a, cif.cmd_b, cif.cmd_opcode}, {8'h12, 3'd3});
    check("ovr_count", seen_overrun, 1);
    @(posedge clock);
    #1 cif.cmd_ready = 1'b1;
    held = 0;
    repeat (2) @(negedge clock);
    check("ovr_cleared", cif.cmd_valid, 0);
    check_counts("overrun");

    // Short glitch on rx
    busy_cycles = 0;
    rx = 1'b0;
    for (int i = 0; i < 3 * CPB; i++) begin
      if (i == 2) rx = 1'b1;
      @(negedge clock);
      if (rx_busy) busy_cycles++;
    end
    check("glitch_busy", (busy_cycles > 0 && busy_cycles <= CPB / 2), 1);
    check("glitch_idle", rx_busy, 0);

    // Reset in the middle of byte1's data bits
    check("pre_reset_q", exp_q.size(), 0);
    send(8'h21);
    rx = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      rx = i[0];
      repeat (CPB) @(negedge clock);
    end
    reset_n = 1'b0;
    rx      = 1'b1;
    have_b0 = 0;
    @(negedge clock);
    check("midrst_valid", cif.cmd_valid, 0);
    check("midrst_fields", {cif.cmd_a, cif.cmd_b, cif.cmd_opcode}, 0);
    check("midrst_busy", rx_busy, 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    send(8'h9C);
    send(8'hA6);
    idle_bits(2);
    check_counts("midrst");

    // Randomized frames, some with bad headers or timeouts
    for (int k = 0; k < 30; k++) begin
      x0 = 8'($urandom);
      x1 = ($urandom_range(1, 0) == 1) ? {HDR, 3'($urandom)} : 8'($urandom);
      send(x0);
      if ($urandom_range(5, 0) == 0) idle_bits(25);
      else idle_bits($urandom_range(3, 0));
      send(x1);
      idle_bits($urandom_range(3, 0));
    end
    idle_bits(25);
    check_counts("random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
